// File: rtl/rsa_avm_bridge.sv
// rsa_avm_bridge: Avalon-MM master that pulls modulus, exponent and base bytes
// from a UART, runs the exponentiation core, and sends the result back.
//
//   state     | meaning
//   POLL_RX   | reading status, waiting for a received byte
//   READ_RX   | reading the RX data register, shifting it into N/D/A
//   WAIT_CORE | bus idle, waiting for the core to finish
//   POLL_TX   | reading status, waiting for TX room
//   WRITE_TX  | writing one result byte to the TX register
module rsa_avm_bridge #(
  parameter int KEY_BITS    = 256,
  parameter int OUT_BYTES   = KEY_BITS / 8 - 1,
  parameter int RX_BASE     = 0,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int TX_OK_BIT   = 6,
  parameter int RX_OK_BIT   = 7
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  output logic [4:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  output logic                core_start,
  output logic [KEY_BITS-1:0] core_n,
  output logic [KEY_BITS-1:0] core_d,
  output logic [KEY_BITS-1:0] core_a,
  input  logic [KEY_BITS-1:0] core_result,
  input  logic                core_finished,
  input  logic                key_reload,
  output logic [15:0]         block_count
);

  localparam int KB = KEY_BITS / 8;
  localparam int CW = $clog2(KB + 1);

  typedef enum logic [2:0] {POLL_RX, READ_RX, WAIT_CORE, POLL_TX, WRITE_TX} state_t;
  typedef enum logic [1:0] {PH_N, PH_D, PH_A} phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q;
  logic [CW-1:0]       cnt_q;
  logic [KEY_BITS-1:0] tx_shift_q;
  logic                reload_pending_q;

  logic [4:0]  addr_d;
  logic        read_d, write_d, start_d;
  logic [31:0] wdata_d;
  logic        xfer, rx_take, rx_last, tx_load, tx_sent, tx_last;

  // Only the low byte and the two status flags of readdata carry information.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:8];

  assign xfer = (avm_read | avm_write) & ~avm_waitrequest;

  // Next-state and next bus request; bus outputs only move on completion.
  always_comb begin
    state_d = state_q;
    addr_d  = avm_address;
    read_d  = avm_read;
    write_d = avm_write;
    wdata_d = avm_writedata;
    start_d = 1'b0;
    rx_take = 1'b0;
    rx_last = 1'b0;
    tx_load = 1'b0;
    tx_sent = 1'b0;
    tx_last = 1'b0;
    case (state_q)
      POLL_RX: begin
        if (xfer && avm_readdata[RX_OK_BIT]) begin
          addr_d  = 5'(RX_BASE);
          state_d = READ_RX;
        end
      end
      READ_RX: begin
        if (xfer) begin
          rx_take = 1'b1;
          rx_last = (cnt_q == CW'(KB - 1));
          if (rx_last && phase_q == PH_A) begin
            read_d  = 1'b0;
            start_d = 1'b1;
            state_d = WAIT_CORE;
          end else begin
            addr_d  = 5'(STATUS_BASE);
            state_d = POLL_RX;
          end
        end
      end
      WAIT_CORE: begin
        if (core_finished) begin
          tx_load = 1'b1;
          read_d  = 1'b1;
          addr_d  = 5'(STATUS_BASE);
          state_d = POLL_TX;
        end
      end
      POLL_TX: begin
        if (xfer && avm_readdata[TX_OK_BIT]) begin
          read_d  = 1'b0;
          write_d = 1'b1;
          addr_d  = 5'(TX_BASE);
          wdata_d = {24'd0, tx_shift_q[KEY_BITS-1 -: 8]};
          state_d = WRITE_TX;
        end
      end
      WRITE_TX: begin
        if (xfer) begin
          tx_sent = 1'b1;
          tx_last = (cnt_q == CW'(OUT_BYTES - 1));
          write_d = 1'b0;
          wdata_d = 32'd0;
          read_d  = 1'b1;
          addr_d  = 5'(STATUS_BASE);
          state_d = tx_last ? POLL_RX : POLL_TX;
        end
      end
      default: begin
        read_d  = 1'b1;
        write_d = 1'b0;
        wdata_d = 32'd0;
        addr_d  = 5'(STATUS_BASE);
        state_d = POLL_RX;
      end
    endcase
  end

  // State and registered bus/start outputs.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q       <= POLL_RX;
      avm_address   <= 5'(STATUS_BASE);
      avm_read      <= 1'b1;
      avm_write     <= 1'b0;
      avm_writedata <= 32'd0;
      core_start    <= 1'b0;
    end else begin
      state_q       <= state_d;
      avm_address   <= addr_d;
      avm_read      <= read_d;
      avm_write     <= write_d;
      avm_writedata <= wdata_d;
      core_start    <= start_d;
    end
  end

  // Operand loading, result shifting, byte counter, phase and block count.
  // The result is pre-shifted so the first byte to send sits at the top.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      core_n      <= '0;
      core_d      <= '0;
      core_a      <= '0;
      tx_shift_q  <= '0;
      cnt_q       <= '0;
      phase_q     <= PH_N;
      block_count <= 16'd0;
    end else begin
      if (rx_take) begin
        case (phase_q)
          PH_N:    core_n <= {core_n[KEY_BITS-9:0], avm_readdata[7:0]};
          PH_D:    core_d <= {core_d[KEY_BITS-9:0], avm_readdata[7:0]};
          default: core_a <= {core_a[KEY_BITS-9:0], avm_readdata[7:0]};
        endcase
        if (rx_last) begin
          cnt_q <= '0;
          if (phase_q == PH_N)      phase_q <= PH_D;
          else if (phase_q == PH_D) phase_q <= PH_A;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (tx_load) begin
        tx_shift_q <= core_result << (8 * (KB - OUT_BYTES));
        cnt_q      <= '0;
      end
      if (tx_sent) begin
        tx_shift_q <= tx_shift_q << 8;
        if (tx_last) begin
          cnt_q       <= '0;
          block_count <= block_count + 16'd1;
          phase_q     <= reload_pending_q ? PH_N : PH_A;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // Key reload request; a new request in the consuming cycle wins.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) reload_pending_q <= 1'b0;
    else         reload_pending_q <= key_reload | (reload_pending_q & ~(tx_sent & tx_last));
  end

endmodule

// File: tb/tb_rsa_avm_bridge.sv
// Scoreboard bench for rsa_avm_bridge with KEY_BITS=32, OUT_BYTES=3: a UART
// slave model with random stalls and status flags, a core model, and queues
// of expected keys and TX bytes derived from the bytes the bench sends.
module tb_rsa_avm_bridge;
  localparam int KEY_BITS = 32;
  localparam int OUT_BYTES = 3;
  localparam int NB = 8;
  localparam logic [4:0] A_RX = 5'd0, A_TX = 5'd4, A_ST = 5'd8;

  logic        avm_clk = 1'b0, avm_rst = 1'b1;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write, avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0, avm_writedata;
  logic        core_start, core_finished = 1'b0, key_reload = 1'b0;
  logic [31:0] core_n, core_d, core_a, core_result = 32'd0;
  logic [15:0] block_count;

  rsa_avm_bridge #(.KEY_BITS(KEY_BITS), .OUT_BYTES(OUT_BYTES)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .core_start(core_start), .core_n(core_n), .core_d(core_d), .core_a(core_a),
    .core_result(core_result), .core_finished(core_finished),
    .key_reload(key_reload), .block_count(block_count));

  always #5 avm_clk = ~avm_clk;

  int n_checks = 0, n_err = 0;
  logic [7:0]  rx_fifo[$];
  logic [7:0]  exp_tx[$];
  logic [95:0] exp_key[$];
  logic [31:0] res_q[$];
  bit          reload_q[$];
  int          blocks_done = 0, blk_idx = 0, tx_in_blk = 0;
  bit          stop_mon = 0, rx_ok_seen = 0, tx_ok_seen = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Slave: drive waitrequest and readdata shortly after each rising edge.
  int stall_left = 0;
  initial begin : slave_drive
    forever begin
      @(posedge avm_clk); #1;
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1; stall_left--;
      end else if (avm_read && avm_address == A_RX && $urandom_range(0, 3) == 0) begin
        avm_waitrequest = 1'b1; stall_left = 2;
      end else begin
        avm_waitrequest = ($urandom_range(0, 3) == 0);
      end
      if (avm_address == A_ST)
        avm_readdata = {$urandom} & 32'hFFFF_FF3F
                     | {24'd0, (rx_fifo.size() > 0 && $urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 6'd0};
      else if (avm_address == A_RX && rx_fifo.size() > 0)
        avm_readdata = {$urandom} & 32'hFFFF_FF00 | {24'd0, rx_fifo[0]};
      else
        avm_readdata = $urandom;
    end
  end

  // Monitor: act on completions and check bus rules, sampled mid-cycle.
  bit          pend = 0, bc_due = 0;
  logic [38:0] pend_bus;
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge avm_clk);
      if (!stop_mon && !avm_rst) begin
        if (bc_due) begin chk("block_count", block_count, blocks_done); bc_due = 0; end
        if (pend) begin chk("bus_stable", {avm_address, avm_read, avm_write, avm_writedata}, pend_bus); pend = 0; end
        if (avm_read && avm_write) chk("rd_wr_excl", 1, 0);
        if ((avm_read || avm_write) && avm_waitrequest) begin
          pend = 1; pend_bus = {avm_address, avm_read, avm_write, avm_writedata};
        end
        if (avm_read && !avm_waitrequest) begin
          if (avm_address == A_ST) begin
            rx_ok_seen = avm_readdata[7]; tx_ok_seen = avm_readdata[6];
          end else if (avm_address == A_RX) begin
            chk("rx_after_ok", rx_ok_seen, 1);
            if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
            else chk("rx_fifo_underrun", 1, 0);
            rx_ok_seen = 0;
          end
        end
        if (avm_write && !avm_waitrequest) begin
          chk("tx_after_ok", tx_ok_seen, 1);
          tx_ok_seen = 0;
          chk("tx_addr", avm_address, A_TX);
          if (exp_tx.size() == 0) chk("tx_unexpected", avm_writedata, 32'hFFFF_FFFF);
          else begin
            e = exp_tx.pop_front();
            chk("tx_byte", avm_writedata, {24'd0, e});
          end
          tx_in_blk++;
          if (tx_in_blk == OUT_BYTES) begin
            tx_in_blk = 0; blocks_done++; bc_due = 1;
          end
        end
      end
    end
  end

  // Core model: check operands on start, answer after a random delay.
  initial begin : core_model
    logic [95:0] k;
    logic [31:0] r;
    int dly;
    forever begin
      @(negedge avm_clk);
      if (core_start && !stop_mon && !avm_rst) begin
        if (exp_key.size() == 0) begin chk("start_unexpected", 1, 0); k = '0; end
        else begin
          k = exp_key.pop_front();
          chk("core_key", {core_n, core_d, core_a}, k);
        end
        r = (res_q.size() > 0) ? res_q.pop_front() : $urandom;
        exp_tx.push_back(r[23:16]); exp_tx.push_back(r[15:8]); exp_tx.push_back(r[7:0]);
        chk("bus_idle_start", {avm_read, avm_write}, 2'b00);
        if (blk_idx + 1 < reload_q.size() && reload_q[blk_idx + 1]) key_reload = 1'b1;
        blk_idx++;
        dly = $urandom_range(1, 6);
        repeat (dly) begin
          @(negedge avm_clk);
          key_reload = 1'b0;
          if (stop_mon) break;
          chk("start_one_cycle", core_start, 0);
          chk("key_stable", {core_n, core_d, core_a}, k);
        end
        core_result = r; core_finished = 1'b1;
        @(negedge avm_clk);
        core_finished = 1'b0; core_result = $urandom;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rx_fifo.push_back(w[8*i +: 8]);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_read"}, avm_read, 1);
    chk({tag, "_addr"}, avm_address, A_ST);
    chk({tag, "_write"}, avm_write, 0);
    chk({tag, "_wdata"}, avm_writedata, 0);
    chk({tag, "_start"}, core_start, 0);
    chk({tag, "_keys"}, {core_n, core_d, core_a}, 96'd0);
    chk({tag, "_bc"}, block_count, 0);
  endtask

  initial begin : main
    logic [31:0] n, d, a;
    int t;
    repeat (3) @(negedge avm_clk);
    check_reset_values("reset");
    // Build the stimulus and the expected operand sequence.
    n = 32'h0000_00C5; d = 32'h0000_0007;
    for (int b = 0; b < NB; b++) begin
      bit rl;
      rl = (b == 0) || (b == 3) || (b > 3 && $urandom_range(0, 2) == 0);
      reload_q.push_back(rl);
      if (b == 0)      a = 32'h0000_0002;
      else if (b == 1) a = 32'h0000_0005;
      else             a = $urandom;
      if (rl) begin
        if (b != 0) begin n = $urandom; d = $urandom; end
        push_word(n); push_word(d);
      end
      push_word(a);
      exp_key.push_back({n, d, a});
    end
    res_q.push_back(32'hAA11_2233);
    avm_rst = 1'b0;
    t = 0;
    while (blocks_done < NB && t < 20000) begin @(negedge avm_clk); t++; end
    chk("blocks_timeout", blocks_done, NB);
    repeat (2) @(negedge avm_clk);
    chk("final_block_count", block_count, NB);
    chk("rx_drained", rx_fifo.size(), 0);
    chk("tx_drained", exp_tx.size(), 0);
    chk("keys_drained", exp_key.size(), 0);
    // One more block with the same key, then reset while a TX write is pending.
    reload_q.push_back(1'b0);
    a = $urandom;
    push_word(a);
    exp_key.push_back({n, d, a});
    t = 0;
    while (!avm_write && t < 5000) begin @(negedge avm_clk); t++; end
    chk("reach_tx_timeout", avm_write, 1);
    stop_mon = 1;
    avm_rst = 1'b1;
    #1;
    check_reset_values("midtx_reset");
    repeat (2) @(negedge avm_clk);
    check_reset_values("held_reset");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/rsa_avm_bridge.md
RSA_AVM_BRIDGE -- requirements
Module: rsa_avm_bridge

Interface
REQ-001 SHALL have parameter KEY_BITS, default 256, operand width in bits; legal range 16..1024 and a multiple of 8; KB = KEY_BITS/8.
REQ-002 SHALL have parameter OUT_BYTES, default KB-1, number of result bytes transmitted per block; legal range 1..KB.
REQ-003 SHALL have parameters RX_BASE=0, TX_BASE=4, STATUS_BASE=8, TX_OK_BIT=6, RX_OK_BIT=7, giving UART register addresses and status bits.
REQ-004 avm_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 avm_rst  in  1  asynchronous, active-high reset.
REQ-006 avm_address  out  5  Avalon-MM address.
REQ-007 avm_read  out  1  Avalon-MM read request.
REQ-008 avm_readdata  in  32  Avalon-MM read data.
REQ-009 avm_write  out  1  Avalon-MM write request.
REQ-010 avm_writedata  out  32  Avalon-MM write data; bits [31:8] always 0.
REQ-011 avm_waitrequest  in  1  slave stall.
REQ-012 core_start  out  1  one-cycle start pulse to the exponentiation core.
REQ-013 core_n, core_d, core_a  out  KEY_BITS each  modulus, exponent, base registers.
REQ-014 core_result  in  KEY_BITS  core result, valid when core_finished=1.
REQ-015 core_finished  in  1  core completion pulse.
REQ-016 key_reload  in  1  request to reload N and D at the next block boundary.
REQ-017 block_count  out  16  number of completed blocks, wraps 0xFFFF->0.

Function
REQ-018 Bus rule: a transaction completes on a cycle with request high and avm_waitrequest=0; address/read/write SHALL stay stable until completion; avm_read and avm_write never high together.
REQ-019 States: POLL_RX, READ_RX, WAIT_CORE, POLL_TX, WRITE_TX; load phase register: N, D, A.
REQ-020 POLL_RX: read STATUS_BASE; on completion with readdata[RX_OK_BIT]=1 -> read RX_BASE, go READ_RX; with bit=0 -> re-read STATUS_BASE.
REQ-021 READ_RX completion: target register of current phase <= {reg[KEY_BITS-9:0], readdata[7:0]} (MSB-first); byte counter +1.
REQ-022 After the KB-th byte of a phase, phase advances N->D->A and the counter clears; otherwise -> read STATUS_BASE, POLL_RX.
REQ-023 On the KB-th A byte: core_start=1 the following cycle for exactly one cycle, bus idle (read=write=0), go WAIT_CORE.
REQ-024 core_n/d/a SHALL not change outside READ_RX completions; they are stable throughout WAIT_CORE.
REQ-025 WAIT_CORE: on core_finished=1 latch core_result into the TX shift register, clear the counter, read STATUS_BASE, go POLL_TX; core_finished in any other state is ignored.
REQ-026 POLL_TX: completion with readdata[TX_OK_BIT]=1 -> write TX_BASE, go WRITE_TX; else re-read STATUS_BASE.
REQ-027 Byte k (k=0..OUT_BYTES-1) on avm_writedata[7:0] = result[8*(OUT_BYTES-k)-1 -: 8]; the top KB-OUT_BYTES bytes are never sent.
REQ-028 WRITE_TX completion: counter +1; on the OUT_BYTES-th byte, block_count +1, read STATUS_BASE, go POLL_RX; otherwise read STATUS_BASE, go POLL_TX.
REQ-029 Next phase after a block is A (key reused) unless key_reload_pending=1, which selects N and clears the pending flag.
REQ-030 key_reload=1 in any cycle sets key_reload_pending; a simultaneous set and consume leaves the flag set.

Reset
REQ-031 On avm_rst: state POLL_RX, phase N, avm_read=1, avm_address=STATUS_BASE, avm_write=0, avm_writedata=0, core_start=0, core_n/d/a=0, counters=0, block_count=0, key_reload_pending=0; reset mid-transaction abandons it without a completion.

Verification (KEY_BITS=32, OUT_BYTES=3)
REQ-032 RX bytes 00 00 00 C5, 00 00 00 07, 00 00 00 02 -> core_n=0xC5, core_d=0x07, core_a=0x02, single core_start pulse.
REQ-033 core_result=0xAA112233 with core_finished -> TX writes 0x11, 0x22, 0x33 in order, each preceded by a TX_OK status poll; block_count=1.
REQ-034 Then 4 more RX bytes 00 00 00 05 -> core_start with core_n=0xC5, core_d=0x07 unchanged, core_a=0x05.
REQ-035 avm_waitrequest held high 3 cycles on an RX read -> address/read stable, byte shifted once only.
REQ-036 key_reload pulse during WAIT_CORE -> after TX, next 12 RX bytes reload N, D, A; reset asserted mid-TX -> all outputs at REQ-031 values.
